// File: rtl/i2s_sched_pkg.sv
// Shared types and constants for the I2S source scheduler.
package i2s_sched_pkg;

    localparam int unsigned BITCNT_W = 5;

    // Transmitter bit position at which it latches sound_in.
    localparam logic [BITCNT_W-1:0] FRAME_LAST = 5'd31;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        SWITCH
    } sched_state_t;

endpackage

// File: rtl/i2s_prio_pick.sv
// Fixed-priority encoder: lowest set request bit wins.
module i2s_prio_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/i2s_source_scheduler.sv
// Shares the I2S left-channel sample slot between NUM_SRC producers with
// fixed priority, a one-frame mute gap on every ownership change and a
// one-sample buffer. Decisions happen only on frame-boundary edges.
// Optional feature: define I2S_SCHED_STATS_EN to add saturating underrun_cnt
// and switch_cnt outputs.
module i2s_source_scheduler
    import i2s_sched_pkg::*;
#(
    parameter  int unsigned NUM_SRC = 4,
    parameter  int unsigned DATA_W  = 16,
    localparam int unsigned IDX_W   = $clog2(NUM_SRC)
) (
    input  logic                      serial_clk,
    input  logic                      reset,
    input  logic [BITCNT_W-1:0]       bit_counter,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC-1:0]        cfg_src_en,
    input  logic                      cfg_underrun_hold,
    output logic [DATA_W-1:0]         sound_in,
    output logic                      grant_valid,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      underrun
`ifdef I2S_SCHED_STATS_EN
    ,
    output logic [15:0]               underrun_cnt,
    output logic [15:0]               switch_cnt
`endif
);

    sched_state_t      state_q;
    logic [DATA_W-1:0] hold_q;
    logic              hold_valid_q;
    logic [DATA_W-1:0] last_q;

    logic [NUM_SRC-1:0] req;
    logic               found;
    logic [IDX_W-1:0]   win_idx;
    logic               boundary;
    logic               take_switch;
    logic               xfer;
    logic               grant_en;
    logic [DATA_W-1:0]  grant_data;

    assign req = cfg_src_en & src_valid;

    i2s_prio_pick #(
        .N     (NUM_SRC),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .found (found),
        .idx   (win_idx)
    );

    // Boundary detect, ready generation and ownership-change decision.
    always_comb begin
        boundary   = (bit_counter == FRAME_LAST);
        grant_en   = cfg_src_en[grant_idx];
        grant_data = src_data[int'(grant_idx)*DATA_W +: DATA_W];
        src_ready  = '0;
        if (state_q == ACTIVE && !hold_valid_q && !boundary) begin
            src_ready[grant_idx] = 1'b1;
        end
        xfer        = |(src_ready & src_valid);
        take_switch = boundary && found &&
                      ((state_q == IDLE) ||
                       (state_q == SWITCH && win_idx < grant_idx) ||
                       (state_q == ACTIVE && win_idx != grant_idx));
    end

    // Scheduler FSM with registered sample, grant and underrun outputs.
    always_ff @(posedge serial_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            last_q       <= '0;
            sound_in     <= '0;
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            underrun     <= 1'b0;
        end else begin
            underrun <= 1'b0;
            // Ready is low on the boundary, so a transfer never races the
            // hold-register drain below.
            if (xfer) begin
                hold_q       <= grant_data;
                hold_valid_q <= 1'b1;
            end
            if (boundary) begin
                case (state_q)
                    IDLE: begin
                        sound_in <= '0;
                        if (take_switch) begin
                            grant_idx   <= win_idx;
                            grant_valid <= 1'b1;
                            state_q     <= SWITCH;
                        end
                    end
                    SWITCH: begin
                        sound_in <= '0;
                        if (take_switch) begin
                            grant_idx <= win_idx;
                        end else begin
                            state_q <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (hold_valid_q) begin
                            sound_in     <= hold_q;
                            last_q       <= hold_q;
                            hold_valid_q <= 1'b0;
                        end else begin
                            sound_in <= cfg_underrun_hold ? last_q : '0;
                            underrun <= 1'b1;
                        end
                        if (take_switch) begin
                            grant_idx <= win_idx;
                            state_q   <= SWITCH;
                        end else if (!grant_en && !found) begin
                            grant_valid <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef I2S_SCHED_STATS_EN
    // Saturating event counters for underruns and ownership changes.
    always_ff @(posedge serial_clk or negedge reset) begin
        if (!reset) begin
            underrun_cnt <= '0;
            switch_cnt   <= '0;
        end else begin
            if (underrun && underrun_cnt != 16'hFFFF) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
            if (take_switch && switch_cnt != 16'hFFFF) begin
                switch_cnt <= switch_cnt + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_i2s_source_scheduler.sv
// Bench for i2s_source_scheduler: directed frame sequences plus random frames,
// checked against a frame-level reference model of the slot-sharing rules.
module tb_i2s_source_scheduler;

    localparam int N = 4;
    localparam int W = 16;

    localparam int ST_IDLE = 0;
    localparam int ST_ACT  = 1;
    localparam int ST_SW   = 2;

    logic           serial_clk = 1'b0;
    logic           reset;
    logic [4:0]     bit_counter;
    logic [N-1:0]   src_valid;
    logic [N*W-1:0] src_data;
    logic [N-1:0]   src_ready;
    logic [N-1:0]   cfg_src_en;
    logic           cfg_underrun_hold;
    logic [W-1:0]   sound_in;
    logic           grant_valid;
    logic [1:0]     grant_idx;
    logic           underrun;
`ifdef I2S_SCHED_STATS_EN
    logic [15:0]    underrun_cnt;
    logic [15:0]    switch_cnt;
`endif

    i2s_source_scheduler #(
        .NUM_SRC (N),
        .DATA_W  (W)
    ) dut (
        .serial_clk        (serial_clk),
        .reset             (reset),
        .bit_counter       (bit_counter),
        .src_valid         (src_valid),
        .src_data          (src_data),
        .src_ready         (src_ready),
        .cfg_src_en        (cfg_src_en),
        .cfg_underrun_hold (cfg_underrun_hold),
        .sound_in          (sound_in),
        .grant_valid       (grant_valid),
        .grant_idx         (grant_idx),
        .underrun          (underrun)
`ifdef I2S_SCHED_STATS_EN
        ,
        .underrun_cnt      (underrun_cnt),
        .switch_cnt        (switch_cnt)
`endif
    );

    always #5 serial_clk = ~serial_clk;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Reference model state.
    int          m_st;
    int          m_g;
    logic        m_gv;
    logic        m_hv;
    logic        m_pulse;
    logic [15:0] m_sound;
    logic [15:0] m_last;
    logic [15:0] m_hold;
    int          m_urun;
    int          m_sw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = ST_IDLE; m_g = 0; m_gv = 1'b0; m_hv = 1'b0; m_pulse = 1'b0;
        m_sound = '0; m_last = '0; m_hold = '0; m_urun = 0; m_sw = 0;
    endtask

    function automatic int winner(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Frame-boundary rules: arbitration, mute gap, sample emission.
    task automatic model_boundary(input logic [N-1:0] en, input logic [N-1:0] v,
                                  input logic hm);
        int w;
        w = winner(en & v);
        m_pulse = 1'b0;
        if (m_st == ST_IDLE) begin
            m_sound = '0;
            if (w >= 0) begin
                m_g = w; m_gv = 1'b1; m_st = ST_SW; m_sw++;
            end
        end else if (m_st == ST_SW) begin
            m_sound = '0;
            if (w >= 0 && w < m_g) begin
                m_g = w; m_sw++;
            end else begin
                m_st = ST_ACT;
            end
        end else begin
            if (m_hv) begin
                m_sound = m_hold; m_last = m_hold; m_hv = 1'b0;
            end else begin
                m_sound = hm ? m_last : 16'h0; m_pulse = 1'b1; m_urun++;
            end
            if (w >= 0 && w != m_g) begin
                m_g = w; m_st = ST_SW; m_sw++;
            end else if (w < 0 && !en[m_g]) begin
                m_st = ST_IDLE; m_gv = 1'b0;
            end
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_sound_in", 32'(sound_in), 32'h0);
        chk("rst_grant_valid", 32'(grant_valid), 32'h0);
        chk("rst_grant_idx", 32'(grant_idx), 32'h0);
        chk("rst_underrun", 32'(underrun), 32'h0);
        chk("rst_src_ready", 32'(src_ready), 32'h0);
`ifdef I2S_SCHED_STATS_EN
        chk("rst_underrun_cnt", 32'(underrun_cnt), 32'h0);
        chk("rst_switch_cnt", 32'(switch_cnt), 32'h0);
`endif
    endtask

    // One 32-bit frame. Valid/enable switch from the *a to the *b values at
    // bit 10; rst_at >= 0 pulses reset mid-cycle at that bit position.
    task automatic frame(input logic [N-1:0] va, input logic [N-1:0] vb,
                         input logic [N-1:0] ena, input logic [N-1:0] enb,
                         input logic hm, input logic [N*W-1:0] dat, input int rst_at);
        int         hs_exp;
        int         hs_obs;
        logic [N-1:0] exp_rdy;
        hs_exp = 0;
        hs_obs = 0;
        for (int b = 0; b < 32; b++) begin
            bit_counter       = 5'(b);
            src_valid         = (b < 10) ? va : vb;
            cfg_src_en        = (b < 10) ? ena : enb;
            src_data          = dat;
            cfg_underrun_hold = hm;
            #1;
            if (b == rst_at) begin
                reset = 1'b0;
                #1;
                chk_reset_values();
                model_reset();
            end
            exp_rdy = (m_st == ST_ACT && !m_hv && b != 31) ? 4'(1 << m_g) : 4'b0;
            chk("src_ready", 32'(src_ready), 32'(exp_rdy));
            if (|(src_valid & src_ready)) hs_obs++;
            if (|(exp_rdy & src_valid)) begin
                m_hold = dat[m_g*W +: W];
                m_hv   = 1'b1;
                hs_exp++;
            end
            @(posedge serial_clk);
            #1;
            if (b == rst_at) reset = 1'b1;
            if (b == 31) model_boundary(enb, vb, hm);
            else m_pulse = 1'b0;
            chk("sound_in", 32'(sound_in), 32'(m_sound));
            chk("grant_valid", 32'(grant_valid), 32'(m_gv));
            chk("grant_idx", 32'(grant_idx), 32'(m_g));
            chk("underrun", 32'(underrun), 32'(m_pulse));
        end
        chk("handshakes_per_frame", 32'(hs_obs), 32'(hs_exp));
    endtask

    function automatic logic [N*W-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic [N-1:0] rea;
        logic [N-1:0] reb;

        reset = 1'b0;
        bit_counter = 5'd0;
        src_valid = '0;
        src_data = '0;
        cfg_src_en = '0;
        cfg_underrun_hold = 1'b0;
        model_reset();
        #2;
        chk_reset_values();
        repeat (2) @(posedge serial_clk);
        #1;
        reset = 1'b1;

        // Idle frame, then source 2 wins: SWITCH gap, then 0x1234 emitted.
        frame(4'b0000, 4'b0000, 4'b1111, 4'b1111, 1'b0, rnd_data(), -1);
        for (int f = 0; f < 3; f++)
            frame(4'b0100, 4'b0100, 4'b1111, 4'b1111, 1'b0, 64'h0000_1234_0000_0000, -1);
        chk("first_sample", 32'(sound_in), 32'h1234);

        // Source 2 streaming, source 0 raises valid mid-frame and takes over.
        frame(4'b0100, 4'b0100, 4'b1111, 4'b1111, 1'b0, rnd_data(), -1);
        frame(4'b0100, 4'b0101, 4'b1111, 4'b1111, 1'b0, rnd_data(), -1);
        for (int f = 0; f < 3; f++)
            frame(4'b0101, 4'b0101, 4'b1111, 4'b1111, 1'b0, rnd_data(), -1);

        // Underrun with hold: last sample 0x7FFF repeats.
        frame(4'b0001, 4'b0001, 4'b1111, 4'b1111, 1'b1, 64'h0000_0000_0000_7FFF, -1);
        frame(4'b0000, 4'b0000, 4'b1111, 4'b1111, 1'b1, rnd_data(), -1);
        chk("underrun_hold_value", 32'(sound_in), 32'h7FFF);
        // Underrun without hold: zero.
        frame(4'b0001, 4'b0001, 4'b1111, 4'b1111, 1'b0, rnd_data(), -1);
        frame(4'b0000, 4'b0000, 4'b1111, 4'b1111, 1'b0, rnd_data(), -1);
        chk("underrun_zero_value", 32'(sound_in), 32'h0);

        // Continuous valid from all: one handshake per frame for 8 frames.
        for (int f = 0; f < 8; f++)
            frame(4'b1111, 4'b1111, 4'b1111, 4'b1111, 1'b0, rnd_data(), -1);

        // Disable the owner mid-frame with no other requester.
        frame(4'b0001, 4'b0001, 4'b1111, 4'b1110, 1'b0, rnd_data(), -1);
        frame(4'b0001, 4'b0001, 4'b1110, 4'b1110, 1'b0, rnd_data(), -1);
        chk("disable_idle_grant", 32'(grant_valid), 32'h0);

        // Reset at bit 17 while ACTIVE, then three forced underruns.
        for (int f = 0; f < 3; f++)
            frame(4'b0010, 4'b0010, 4'b1111, 4'b1111, 1'b0, rnd_data(), -1);
        frame(4'b0010, 4'b0010, 4'b1111, 4'b1111, 1'b0, rnd_data(), 17);
        frame(4'b0010, 4'b0010, 4'b1111, 4'b1111, 1'b0, rnd_data(), -1);
        for (int f = 0; f < 3; f++)
            frame(4'b0000, 4'b0000, 4'b1111, 4'b1111, 1'b1, rnd_data(), -1);
        frame(4'b0010, 4'b0010, 4'b1111, 4'b1111, 1'b0, rnd_data(), -1);
`ifdef I2S_SCHED_STATS_EN
        chk("underrun_cnt", 32'(underrun_cnt), 32'(m_urun));
        chk("switch_cnt", 32'(switch_cnt), 32'(m_sw));
`endif

        // Random frames.
        for (int f = 0; f < 24; f++) begin
            ra  = 4'($urandom);
            rb  = 4'($urandom);
            rea = 4'($urandom) | 4'($urandom);
            reb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : rea;
            frame(ra, rb, rea, reb, 1'($urandom), rnd_data(), -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
